// File: rtl/reg_mem_pkg.sv
// Shared constants and the depth helper for the reg_mem register-file slice.
package reg_mem_pkg;

  localparam int REG_MEM_DATA_WIDTH = 8;
  localparam int REG_MEM_ADDR_BITS  = 5;

  function automatic int reg_mem_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

  localparam int REG_MEM_DEPTH = reg_mem_depth(REG_MEM_ADDR_BITS);

endpackage

// File: rtl/reg_mem_word.sv
// One storage word: load-enabled register cleared asynchronously by rst_n.
module reg_mem_word
  import reg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = REG_MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_mem.sv
// Register-file memory: shared address, synchronous write, combinational read.
// Define REG_MEM_WR_BYPASS_EN for write-first forwarding of data_in to data_out.
module reg_mem
  import reg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = REG_MEM_DATA_WIDTH,
  parameter int ADDR_BITS  = REG_MEM_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = reg_mem_depth(ADDR_BITS);

  logic [DEPTH-1:0]      wr_sel;
  logic [DATA_WIDTH-1:0] words [DEPTH];

  // One-hot write decode feeding each word's load enable.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign wr_sel[i] = wen & (addr == ADDR_BITS'(i));

    reg_mem_word #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_word (
      .clk  (clk),
      .rst_n(rst_n),
      .load (wr_sel[i]),
      .d    (data_in),
      .q    (words[i])
    );
  end

  always_comb begin
`ifdef REG_MEM_WR_BYPASS_EN
    // The shared address means a write always targets the word being read.
    data_out = (rst_n && wen) ? data_in : words[addr];
`else
    data_out = words[addr];
`endif
  end

endmodule

// File: tb/tb_reg_mem.sv
// Self-checking bench for reg_mem: directed table, corner sequences, random vs array model.
module tb_reg_mem;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic       wen;
  logic [7:0] data_out;

  int n_tests;
  int n_fail;

  logic [7:0] model [32];

`ifdef REG_MEM_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [4:0] addr;
    logic [7:0] din;
    logic       wen;
    logic [4:0] chk_addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [9];

  reg_mem dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .data_in (data_in),
    .wen     (wen),
    .data_out(data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = clk_en ? ~clk : 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [4:0] a, input logic w,
                                            input logic [7:0] d, input logic rn);
    if (BYPASS && w && rn) return d;
    return model[a];
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk_en  = 1'b0;
    wen     = 1'b0;
    addr    = '0;
    data_in = '0;
    rst_n   = 1'b1;

    // Reset with no clock running
    #3 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    for (int i = 0; i < 32; i++) begin
      addr = 5'(i);
      #1 check($sformatf("reset_clear[%0d]", i), data_out, 8'h00);
    end

    clk_en = 1'b1;

    // Fill and read back
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      addr = 5'(i); data_in = 8'(i + 10); wen = 1'b1;
      @(posedge clk);
      model[i] = 8'(i + 10);
    end
    @(negedge clk);
    wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addr = 5'(i);
      #1 check($sformatf("fill_read[%0d]", i), data_out, 8'(i + 10));
    end

    // Directed table: one clock per record, then read back chk_addr
    vecs[0] = '{5'd5,  8'hAA, 1'b0, 5'd5,  8'd15};
    vecs[1] = '{5'd5,  8'hAA, 1'b0, 5'd5,  8'd15};
    vecs[2] = '{5'd5,  8'hAA, 1'b0, 5'd5,  8'd15};
    vecs[3] = '{5'd7,  8'h5A, 1'b1, 5'd7,  8'h5A};
    vecs[4] = '{5'd7,  8'h11, 1'b0, 5'd6,  8'd16};
    vecs[5] = '{5'd7,  8'h22, 1'b0, 5'd8,  8'd18};
    vecs[6] = '{5'd0,  8'hC3, 1'b1, 5'd0,  8'hC3};
    vecs[7] = '{5'd31, 8'h01, 1'b1, 5'd31, 8'h01};
    vecs[8] = '{5'd31, 8'hEE, 1'b0, 5'd30, 8'd40};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      addr = vecs[k].addr; data_in = vecs[k].din; wen = vecs[k].wen;
      @(posedge clk);
      if (vecs[k].wen) model[vecs[k].addr] = vecs[k].din;
      #1 wen = 1'b0;
      addr = vecs[k].chk_addr;
      #1 check($sformatf("table[%0d]", k), data_out, vecs[k].exp);
      check($sformatf("table_model[%0d]", k), data_out, model[vecs[k].chk_addr]);
    end

    // Read during write on addr 9 (holds 19)
    @(negedge clk);
    addr = 5'd9; data_in = 8'h33; wen = 1'b1;
    #1 check("rdw_before_edge", data_out, BYPASS ? 8'h33 : 8'd19);
    @(posedge clk);
    model[9] = 8'h33;
    #1 check("rdw_after_edge", data_out, 8'h33);
    wen = 1'b0;
    #1 check("rdw_after_wen_low", data_out, 8'h33);

    // Randomized traffic against the array model
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      addr    = 5'($urandom_range(0, 31));
      data_in = 8'($urandom);
      wen     = ($urandom_range(0, 2) != 0);
      #1 check("rand_pre", data_out, model_read(addr, wen, data_in, rst_n));
      @(posedge clk);
      if (wen) model[addr] = data_in;
      #1 check("rand_post", data_out, model_read(addr, wen, data_in, rst_n));
    end

    // Async reset asserted before an edge with a write pending
    @(negedge clk);
    addr = 5'd3; data_in = 8'hFF; wen = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("rst_mid_write_pre", data_out, 8'h00);
    @(posedge clk);
    #1 check("rst_mid_write_post", data_out, 8'h00);
    @(negedge clk);
    wen = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    for (int i = 0; i < 32; i++) begin
      addr = 5'(i);
      #1 check($sformatf("rst_all_zero[%0d]", i), data_out, model[i]);
    end

    // Write after reset release still works
    @(negedge clk);
    addr = 5'd3; data_in = 8'h6C; wen = 1'b1;
    @(posedge clk);
    #1 wen = 1'b0;
    #1 check("post_reset_write", data_out, 8'h6C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
